// File: rtl/pipeline_stall_ctrl.sv
// Central pipeline control for the 5-stage core: arbitrates memory stalls, redirects,
// data hazards and HALT into per-stage write enables, flushes and bubbles.
module pipeline_stall_ctrl #(
  parameter int FLUSH_DEPTH = 1,
  parameter int MAX_DSTALL  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard,
  input  logic        branch_taken,
  input  logic        mem_busy,
  input  logic        halt_decode,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        ex_mem_we,
  output logic        mem_wb_we,
  output logic        halted,
  output logic        stall_err,
  output logic [15:0] stall_cycles
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DSTALL = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam logic [1:0] HALT   = 2'd3;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);
  localparam logic [3:0] DSTALL_LIMIT = 4'(MAX_DSTALL);

  logic [1:0] state, state_nxt;
  logic [2:0] flush_cnt, flush_cnt_nxt;
  logic [3:0] dstall_cnt, dstall_cnt_nxt;
  logic       err_set;

  always_comb begin
    state_nxt      = state;
    flush_cnt_nxt  = flush_cnt;
    dstall_cnt_nxt = dstall_cnt;
    err_set        = 1'b0;
    pc_we          = 1'b1;
    if_id_we       = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    ex_mem_we      = 1'b1;
    mem_wb_we      = 1'b1;

    if (!rst) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_we    = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (state == HALT) begin
      // Older instructions keep draining; nothing new enters the pipe.
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      ex_mem_we = 1'b0;
      mem_wb_we = 1'b0;
    end else if (branch_taken) begin
      if_id_flush    = 1'b1;
      id_ex_bubble   = 1'b1;
      dstall_cnt_nxt = 4'd0;
      if (FLUSH_DEPTH > 1) begin
        state_nxt     = FLUSH;
        flush_cnt_nxt = FLUSH_RELOAD;
      end else begin
        state_nxt     = RUN;
        flush_cnt_nxt = 3'd0;
      end
    end else if (state == FLUSH) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      if (flush_cnt <= 3'd1) begin
        state_nxt     = RUN;
        flush_cnt_nxt = 3'd0;
      end else begin
        flush_cnt_nxt = flush_cnt - 3'd1;
      end
    end else if (hazard) begin
      pc_we          = 1'b0;
      if_id_we       = 1'b0;
      id_ex_bubble   = 1'b1;
      state_nxt      = DSTALL;
      dstall_cnt_nxt = (dstall_cnt == 4'd15) ? 4'd15 : dstall_cnt + 4'd1;
      err_set        = (dstall_cnt == DSTALL_LIMIT);
    end else begin
      dstall_cnt_nxt = 4'd0;
      state_nxt      = halt_decode ? HALT : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      flush_cnt    <= 3'd0;
      dstall_cnt   <= 4'd0;
      halted       <= 1'b0;
      stall_err    <= 1'b0;
      stall_cycles <= 16'd0;
    end else begin
      state      <= state_nxt;
      flush_cnt  <= flush_cnt_nxt;
      dstall_cnt <= dstall_cnt_nxt;
      halted     <= (state_nxt == HALT);
      if (err_set)
        stall_err <= 1'b1;
      // HALT freezes the PC by design, so it is not counted as a stall.
      if (state != HALT && !pc_we && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with FLUSH_DEPTH=3, MAX_DSTALL=3;
// expected values are hand-computed per cycle.
module tb_pipeline_stall_ctrl;

  logic        clk;
  logic        rst;
  logic        hazard;
  logic        branch_taken;
  logic        mem_busy;
  logic        halt_decode;
  logic        pc_we;
  logic        if_id_we;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        ex_mem_we;
  logic        mem_wb_we;
  logic        halted;
  logic        stall_err;
  logic [15:0] stall_cycles;

  int checkCount;
  int passCount;

  // Control vector order: {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we}
  localparam logic [5:0] NORMAL = 6'b110011;
  localparam logic [5:0] DSTALL = 6'b000111;
  localparam logic [5:0] REDIR  = 6'b111111;
  localparam logic [5:0] MEMSTL = 6'b000000;
  localparam logic [5:0] HALTV  = 6'b000111;
  localparam logic [5:0] RESETV = 6'b000100;

  pipeline_stall_ctrl #(
    .FLUSH_DEPTH(3),
    .MAX_DSTALL (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hazard      (hazard),
    .branch_taken(branch_taken),
    .mem_busy    (mem_busy),
    .halt_decode (halt_decode),
    .pc_we       (pc_we),
    .if_id_we    (if_id_we),
    .if_id_flush (if_id_flush),
    .id_ex_bubble(id_ex_bubble),
    .ex_mem_we   (ex_mem_we),
    .mem_wb_we   (mem_wb_we),
    .halted      (halted),
    .stall_err   (stall_err),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    if (observed === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  task automatic checkCtrl(input string tag, input logic [5:0] expected);
    checkOutput(tag, {10'd0, pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we},
                {10'd0, expected});
  endtask

  task automatic applyStimulus(input logic hz, input logic br, input logic mb, input logic hd);
    @(negedge clk);
    hazard       = hz;
    branch_taken = br;
    mem_busy     = mb;
    halt_decode  = hd;
    #1;
  endtask

  initial begin
    checkCount   = 0;
    passCount    = 0;
    rst          = 1'b0;
    hazard       = 1'b0;
    branch_taken = 1'b0;
    mem_busy     = 1'b0;
    halt_decode  = 1'b0;
    #2;
    checkCtrl("reset_ctrl", RESETV);
    checkOutput("reset_stall_cycles", stall_cycles, 16'd0);
    checkOutput("reset_halted", {15'd0, halted}, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    // Idle run after reset release
    applyStimulus(0, 0, 0, 0);
    checkCtrl("run_ctrl", NORMAL);
    checkOutput("run_stall_cycles", stall_cycles, 16'd0);
    checkOutput("run_halted", {15'd0, halted}, 16'd0);

    // Two-cycle data stall
    applyStimulus(1, 0, 0, 0);
    checkCtrl("dstall1_ctrl", DSTALL);
    applyStimulus(1, 0, 0, 0);
    checkCtrl("dstall2_ctrl", DSTALL);
    applyStimulus(0, 0, 0, 0);
    checkCtrl("dstall_exit_ctrl", NORMAL);
    checkOutput("dstall_cycles", stall_cycles, 16'd2);
    checkOutput("dstall_no_err", {15'd0, stall_err}, 16'd0);

    // Runaway data stall: error flag visible after the 4th stall cycle
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, 0, 0, 0);
      checkCtrl($sformatf("long_stall%0d_ctrl", i), DSTALL);
      checkOutput($sformatf("long_stall%0d_err", i), {15'd0, stall_err}, (i == 5) ? 16'd1 : 16'd0);
    end
    applyStimulus(0, 0, 0, 0);
    checkCtrl("long_exit_ctrl", NORMAL);
    checkOutput("long_err_sticky", {15'd0, stall_err}, 16'd1);
    checkOutput("long_cycles", stall_cycles, 16'd7);

    // Redirect with hazard present: three flush cycles, hazard ignored
    applyStimulus(1, 1, 0, 0);
    checkCtrl("redir_ctrl", REDIR);
    applyStimulus(1, 0, 0, 0);
    checkCtrl("flush2_ctrl", REDIR);
    applyStimulus(1, 0, 0, 0);
    checkCtrl("flush3_ctrl", REDIR);
    applyStimulus(0, 0, 0, 0);
    checkCtrl("flush_exit_ctrl", NORMAL);
    checkOutput("flush_cycles", stall_cycles, 16'd7);

    // mem_busy outranks branch and hazard; branch is dropped
    applyStimulus(1, 1, 1, 0);
    checkCtrl("mem_ctrl", MEMSTL);
    applyStimulus(1, 0, 0, 0);
    checkCtrl("mem_then_dstall_ctrl", DSTALL);
    applyStimulus(0, 0, 0, 0);
    checkCtrl("mem_exit_ctrl", NORMAL);
    checkOutput("mem_cycles", stall_cycles, 16'd9);

    // mem_busy during FLUSH holds the flush count
    applyStimulus(0, 1, 0, 0);
    checkCtrl("redir_b_ctrl", REDIR);
    applyStimulus(0, 0, 1, 0);
    checkCtrl("flush_mem_ctrl", MEMSTL);
    applyStimulus(0, 0, 0, 0);
    checkCtrl("flush_b2_ctrl", REDIR);
    applyStimulus(0, 0, 0, 0);
    checkCtrl("flush_b3_ctrl", REDIR);
    applyStimulus(0, 0, 0, 0);
    checkCtrl("flush_b_exit_ctrl", NORMAL);
    checkOutput("flush_b_cycles", stall_cycles, 16'd10);

    // HALT entry and lock-in
    applyStimulus(0, 0, 0, 1);
    checkCtrl("halt_entry_ctrl", NORMAL);
    checkOutput("halt_entry_halted", {15'd0, halted}, 16'd0);
    applyStimulus(1, 1, 1, 0);
    checkCtrl("halt_ctrl", HALTV);
    checkOutput("halt_halted", {15'd0, halted}, 16'd1);
    applyStimulus(1, 0, 0, 0);
    checkCtrl("halt_hold_ctrl", HALTV);
    checkOutput("halt_cycles", stall_cycles, 16'd10);

    // Asynchronous reset out of HALT
    rst = 1'b0;
    #1;
    checkCtrl("rst2_ctrl", RESETV);
    checkOutput("rst2_halted", {15'd0, halted}, 16'd0);
    checkOutput("rst2_err", {15'd0, stall_err}, 16'd0);
    checkOutput("rst2_cycles", stall_cycles, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    checkCtrl("rst2_run_ctrl", NORMAL);
    checkOutput("rst2_run_halted", {15'd0, halted}, 16'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central pipeline-control block that consumes the decode-stage data-hazard flag and the other stall/redirect sources, and drives the per-stage pipeline-register write enables, flushes and bubble injection for the 5-stage core. It sits beside the decode-stage hazard detector and is the only block allowed to freeze the PC and the IF/ID, EX/MEM and MEM/WB registers. It also tracks halt state, counts stall cycles and flags runaway data stalls.

Parameters:
FLUSH_DEPTH, 1, cycles of IF/ID flush + ID/EX bubble after a taken redirect (legal 1..4)
MAX_DSTALL, 3, max consecutive data-hazard stall cycles before stall_err is set (legal 1..15)

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous active-low reset
hazard  input  1  decode-stage RAW hazard from the data hazard detector
branch_taken  input  1  execute-stage taken branch/jump redirect, valid 1 cycle
mem_busy  input  1  data-memory stall request
halt_decode  input  1  HALT opcode present in decode
pc_we  output  1  PC write enable
if_id_we  output  1  IF/ID register write enable
if_id_flush  output  1  load NOP into IF/ID
id_ex_bubble  output  1  load NOP into ID/EX instead of decode output
ex_mem_we  output  1  EX/MEM write enable
mem_wb_we  output  1  MEM/WB write enable
halted  output  1  registered, core halted
stall_err  output  1  sticky, data stall exceeded MAX_DSTALL
stall_cycles  output  16  saturating count of cycles with pc_we=0, excluding HALT

Behaviour:
- States: RUN, DSTALL, FLUSH, HALT. Reset (rst=0, async): state=RUN, flush_cnt=0, dstall_cnt=0, halted=0, stall_err=0, stall_cycles=0. While rst=0, all *_we=0, if_id_flush=0, id_ex_bubble=1.
- Outputs are combinational from state and inputs; zero latency. Priority per cycle: mem_busy > branch_taken > hazard > halt_decode.
- mem_busy=1 (any non-HALT state): pc_we=if_id_we=ex_mem_we=mem_wb_we=0, if_id_flush=0, id_ex_bubble=0. State, flush_cnt and dstall_cnt hold. A branch_taken that coincides with mem_busy is ignored; the source must re-present it.
- branch_taken=1, mem_busy=0: pc_we=1, if_id_we=1, if_id_flush=1, id_ex_bubble=1, ex_mem_we=mem_wb_we=1. hazard and halt_decode are ignored. If FLUSH_DEPTH>1, go to FLUSH with flush_cnt=FLUSH_DEPTH-1; else go to RUN. dstall_cnt is cleared.
- FLUSH: same outputs as a redirect cycle, without a new redirect (pc_we=1). flush_cnt decrements each non-busy cycle; go to RUN when it reaches 1. A new branch_taken in FLUSH reloads flush_cnt.
- hazard=1 in RUN/DSTALL, no mem_busy/branch: pc_we=0, if_id_we=0, id_ex_bubble=1, ex_mem_we=mem_wb_we=1. Go to DSTALL; dstall_cnt increments, saturating at 15. If hazard=1 while dstall_cnt==MAX_DSTALL, set stall_err (sticky until reset).
- hazard=0 in DSTALL: normal flow (all we=1, no bubble), go to RUN, dstall_cnt=0.
- halt_decode=1 in RUN/DSTALL with no higher-priority event: normal flow this cycle, next state HALT, halted=1 from the next cycle.
- HALT: pc_we=0, if_id_we=0, id_ex_bubble=1, ex_mem_we=mem_wb_we=1 so older instructions drain. All inputs are ignored. Exit only via reset.
- stall_cycles: +1 on every non-HALT cycle with pc_we=0 (mem or data stall). Saturates at 16'hFFFF with no wrap.
- A reset asserted mid-stall or mid-flush returns to the reset values immediately. There is no pending-event memory.

Test Plan:
- Reset release, all inputs 0 -> pc_we=if_id_we=ex_mem_we=mem_wb_we=1, bubble=0, stall_cycles=0, halted=0.
- hazard=1 for 2 cycles then 0 -> 2 cycles of pc_we=0 and id_ex_bubble=1, then RUN. stall_cycles=2, stall_err=0.
- hazard held 5 cycles, MAX_DSTALL=3 -> stall_err rises on the 4th stall cycle and stays 1 after hazard drops.
- FLUSH_DEPTH=3, branch_taken pulse with hazard=1 -> if_id_flush=id_ex_bubble=1 for 3 cycles, pc_we=1 throughout, hazard ignored, stall_cycles unchanged.
- mem_busy=1 together with hazard and branch_taken -> all we=0, bubble=0. Drop mem_busy the next cycle with hazard=1 -> data stall resumes. stall_cycles=2.
- halt_decode=1 -> next cycle halted=1, pc_we=0, ex_mem_we=1; later hazard/branch have no effect. rst=0 then 1 -> RUN, halted=0.
